// File: rtl/mem_access_unit.sv
// Sub-word load/store sequencer between the CPU memory stage and a word-wide data memory.
// Byte/half/word loads are lane-extracted with sign or zero extension; sub-word stores are
// performed as read-modify-write; misaligned or illegal-size requests raise a one-cycle
// error pulse without touching memory.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_*             request (valid, write, size, signed, byte address, store data)
//   stall             hold the pipeline while a request is in flight
//   done, misaligned  one-cycle completion / error pulse (mutually exclusive)
//   load_data         registered load result
//   mem_*             word-wide memory port (index addressing, combinational read data)
module mem_access_unit #(
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned LatchBits = ADDR_BITS + 2;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StFin} state_e;

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic [1:0]             size_q, size_d;
  logic                   signed_q, signed_d;
  logic [LatchBits-1:0]   addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic [31:0]            merge_q, merge_d;
  logic [31:0]            load_data_q, load_data_d;

  logic                   req_misaligned;
  logic [7:0]             lane_b;
  logic [15:0]            lane_h;
  logic [31:0]            extracted;
  logic [31:0]            merged;
  logic [31:0]            word_idx;

  // Address bits above the memory window alias and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:LatchBits];

  assign req_misaligned = (req_size == 2'b11) ||
                          ((req_size == 2'b01) && req_addr[0]) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  assign word_idx = {{(32 - ADDR_BITS){1'b0}}, addr_q[ADDR_BITS+1:2]};

  // Little-endian lanes selected by the latched address.
  assign lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    extracted = mem_rdata;
    case (size_q)
      2'b00:   extracted = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   extracted = {{16{signed_q & lane_h[15]}}, lane_h};
      default: extracted = mem_rdata;
    endcase
  end

  // Read word with the target lane replaced by the low store-data bits.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    merge_d     = merge_q;
    load_data_d = load_data_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr[LatchBits-1:0];
          wdata_d  = req_wdata;
          err_d    = req_misaligned;
          if (req_misaligned) begin
            state_d = StFin;
          end else if (!req_write) begin
            state_d = StRd;
          end else if (req_size == 2'b10) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (write_q) begin
          merge_d = merged;
          state_d = StWr;
        end else begin
          load_data_d = extracted;
          state_d     = StFin;
        end
      end
      StWr:    state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state; memory strobes are masked by reset.
  always_comb begin
    stall      = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      StIdle: stall = req_valid;
      StRd: begin
        stall    = 1'b1;
        mem_read = !reset;
        mem_addr = word_idx;
      end
      StWr: begin
        stall     = 1'b1;
        mem_write = !reset;
        mem_addr  = word_idx;
        mem_wdata = (size_q == 2'b10) ? wdata_q : merge_q;
      end
      StFin: begin
        done       = !err_q;
        misaligned = err_q;
      end
      default: ;
    endcase
  end

  assign load_data = load_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      merge_q     <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      merge_q     <= merge_d;
      load_data_q <= load_data_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand sequences for reset-in-write and
// back-to-back stores, then randomized requests checked against a byte-array memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        misaligned;
  logic [31:0] load_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [64];
  logic [7:0]  sh [256];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  int          wr_total = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BITS(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .misaligned (misaligned),
    .load_data  (load_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[5:0]] <= mem_wdata;
      wr_total <= wr_total + 1;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory with plain arithmetic.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_misal(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = nbytes(sz);
    return (sz == 2'd3) || ((int'(a[7:0]) % n) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a);
    int n;
    int base;
    longint v;
    n = nbytes(sz);
    base = int'(a[7:0]);
    v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(sh[(base + i) % 256]);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    int base;
    n = nbytes(sz);
    base = int'(a[7:0]);
    for (int i = 0; i < n; i++) sh[(base + i) % 256] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] shadow_word(input int idx);
    return {sh[4*idx+3], sh[4*idx+2], sh[4*idx+1], sh[4*idx]};
  endfunction

  task automatic poke(input int idx, input logic [31:0] v);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx[5:0];
    poke_val = v;
    @(posedge clk);
    #1 poke_en = 1'b0;
    for (int i = 0; i < 4; i++) sh[idx*4+i] = v[8*i +: 8];
  endtask

  // Issue one request and watch it until done/misaligned (bounded).
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int cyc, output logic err, output int nrd, output int nwr,
                         output logic side_ok);
    cyc = -1;
    err = 1'b0;
    nrd = 0;
    nwr = 0;
    side_ok = 1'b1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if ((mem_read || mem_write) && mem_addr != {26'b0, a[7:2]}) side_ok = 1'b0;
      if (!(mem_read || mem_write) && (mem_addr != 32'h0 || mem_wdata != 32'h0)) side_ok = 1'b0;
      if (done && misaligned) side_ok = 1'b0;
      if (done || misaligned) begin
        if (stall) side_ok = 1'b0;
        cyc = c;
        err = misaligned;
        req_valid = 1'b0;
        break;
      end else if (!stall) begin
        side_ok = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        init_en;
    logic [31:0] init;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    int          cyc;
    logic        err;
    logic [31:0] exp;  // load_data for loads, memory word for stores
  } vec_t;

  vec_t vt[14];

  initial begin
    int          cyc;
    logic        err;
    int          nrd;
    int          nwr;
    logic        side_ok;
    logic [31:0] exp_ld;
    int          first_done;
    int          second_done;
    logic        stall_at_fin;
    int          wr_base;

    vt[0]  = '{1'b1, 32'h8000_00F0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h8000_00F0};
    vt[1]  = '{1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'hFFFF_FFF0};
    vt[2]  = '{1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h0000_00F0};
    vt[3]  = '{1'b0, 32'h0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF_8000};
    vt[4]  = '{1'b0, 32'h0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 1'b0, 32'h0000_8000};
    vt[5]  = '{1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'hFFFF_FF80};
    vt[6]  = '{1'b1, 32'h1122_3344, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 3, 1'b0,
               32'h1122_AB44};
    vt[7]  = '{1'b1, 32'h1122_3344, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF, 3, 1'b0,
               32'hBEEF_3344};
    vt[8]  = '{1'b0, 32'h0, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 1'b1, 32'hFFFF_FF80};
    vt[9]  = '{1'b1, 32'h1122_3344, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_BEEF, 1, 1'b1,
               32'h1122_3344};
    vt[10] = '{1'b0, 32'h0, 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1, 1'b1, 32'hFFFF_FF80};
    vt[11] = '{1'b0, 32'h0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 1'b0, 32'hDEAD_BEEF};
    vt[12] = '{1'b0, 32'h0, 1'b0, 2'b10, 1'b0, 32'h110, 32'h0, 2, 1'b0, 32'hDEAD_BEEF};
    vt[13] = '{1'b0, 32'h0, 1'b1, 2'b00, 1'b0, 32'hFFFF_FF13, 32'h0000_005A, 3, 1'b0,
               32'h5AAD_BEEF};

    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset stall", {31'b0, stall}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset misaligned", {31'b0, misaligned}, 32'h0);
    chk("reset mem_rw", {30'b0, mem_read, mem_write}, 32'h0);
    chk("reset load_data", load_data, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    exp_ld = 32'h0;

    for (int i = 0; i < 64; i++) poke(i, $urandom);

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      if (vt[i].init_en) poke(4, vt[i].init);
      run_req(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, cyc, err, nrd, nwr, side_ok);
      chk($sformatf("vec%0d latency", i), cyc, vt[i].cyc);
      chk($sformatf("vec%0d error", i), {31'b0, err}, {31'b0, vt[i].err});
      chk($sformatf("vec%0d reads", i), nrd,
          (vt[i].err || (vt[i].w && vt[i].sz == 2'b10)) ? 0 : 1);
      chk($sformatf("vec%0d writes", i), nwr, (vt[i].err || !vt[i].w) ? 0 : 1);
      chk($sformatf("vec%0d side", i), {31'b0, side_ok}, 32'h1);
      if (vt[i].w) begin
        chk($sformatf("vec%0d memword", i), mem[4], vt[i].exp);
        if (!vt[i].err) model_store(vt[i].sz, vt[i].a, vt[i].wd);
      end else begin
        chk($sformatf("vec%0d load_data", i), load_data, vt[i].exp);
        if (!vt[i].err) exp_ld = vt[i].exp;
      end
    end

    // Byte store with reset asserted during the write cycle.
    poke(4, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = 32'h11;
    req_wdata = 32'hAB;
    #1 chk("rstwr c0 stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    #1 chk("rstwr c1 read", {31'b0, mem_read}, 32'h1);
    @(negedge clk);
    #1 chk("rstwr c2 write", {31'b0, mem_write}, 32'h1);
    reset = 1'b1;
    req_valid = 1'b0;
    #1 chk("rstwr c2 gated", {31'b0, mem_write}, 32'h0);
    @(negedge clk);
    #1;
    chk("rstwr c3 flags", {28'b0, stall, done, misaligned, mem_read}, 32'h0);
    chk("rstwr c3 mem_write", {31'b0, mem_write}, 32'h0);
    chk("rstwr c3 mem_addr", mem_addr, 32'h0);
    chk("rstwr c3 mem_wdata", mem_wdata, 32'h0);
    chk("rstwr c3 load_data", load_data, 32'h0);
    chk("rstwr memword", mem[4], 32'h1122_3344);
    reset = 1'b0;
    exp_ld = 32'h0;

    // Two word stores with req_valid held high across the first completion.
    wr_base = wr_total;
    first_done = -1;
    second_done = -1;
    stall_at_fin = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'b10;
    req_addr = 32'h20;
    req_wdata = 32'hCAFE_0001;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (done) begin
        if (first_done < 0) begin
          first_done = c;
          stall_at_fin = stall;
          req_addr = 32'h24;
          req_wdata = 32'hCAFE_0002;
        end else begin
          second_done = c;
          req_valid = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b first done", first_done, 2);
    chk("b2b second done", second_done, 5);
    chk("b2b fin stall", {31'b0, stall_at_fin}, 32'h0);
    chk("b2b write count", wr_total - wr_base, 2);
    chk("b2b word8", mem[8], 32'hCAFE_0001);
    chk("b2b word9", mem[9], 32'hCAFE_0002);
    model_store(2'b10, 32'h20, 32'hCAFE_0001);
    model_store(2'b10, 32'h24, 32'hCAFE_0002);

    // Randomized requests against the byte-array model.
    for (int i = 0; i < 300; i++) begin
      logic        w;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] a;
      logic [31:0] wd;
      logic        e_err;
      int          e_cyc;
      w = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a = $urandom;
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      e_err = model_misal(sz, a);
      e_cyc = e_err ? 1 : (!w || sz == 2'd2) ? 2 : 3;
      run_req(w, sz, sg, a, wd, cyc, err, nrd, nwr, side_ok);
      if (!e_err) begin
        if (w) model_store(sz, a, wd);
        else exp_ld = model_load(sz, sg, a);
      end
      chk($sformatf("rand%0d latency", i), cyc, e_cyc);
      chk($sformatf("rand%0d error", i), {31'b0, err}, {31'b0, e_err});
      chk($sformatf("rand%0d reads", i), nrd, (e_err || (w && sz == 2'd2)) ? 0 : 1);
      chk($sformatf("rand%0d writes", i), nwr, (e_err || !w) ? 0 : 1);
      chk($sformatf("rand%0d side", i), {31'b0, side_ok}, 32'h1);
      chk($sformatf("rand%0d load_data", i), load_data, exp_ld);
      if (w) chk($sformatf("rand%0d memword", i), mem[a[7:2]], shadow_word(int'(a[7:2])));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sub-word load/store sequencer between the CPU memory stage and the word-wide data memory. Accepts byte, halfword and word loads and stores at byte addresses. Converts them into word accesses: sub-word stores become read-modify-write, loads are lane-extracted with sign or zero extension. Stalls the pipeline while a request is in flight and flags misaligned or illegal-size requests without touching memory.

## Interface
Parameters:
- ADDR_BITS, 6, width of the word index forwarded to memory; upper `mem_addr` bits are zero.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present; held stable with all `req_*` until `done` or `misaligned`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `stall`  out  1  freeze the pipeline.
- `done`  out  1  one-cycle completion pulse.
- `misaligned`  out  1  one-cycle error pulse instead of `done`.
- `load_data`  out  32  registered load result.
- `mem_addr`  out  32  word index: {zeros, latched addr[ADDR_BITS+1:2]}.
- `mem_wdata`  out  32  word to write.
- `mem_write`  out  1  write enable; memory writes at the clock edge.
- `mem_read`  out  1  read enable.
- `mem_rdata`  in  32  combinational read data, valid in the same cycle as `mem_addr`.

## Operation
- States: IDLE, RD, WR, FIN. Request fields are latched on accept (IDLE with `req_valid`=1).
- Misaligned condition:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - size 11.
- Transitions from IDLE on accept:
  - misaligned → FIN with error flag set;
  - load → RD;
  - word store → WR;
  - byte/half store → RD.
- RD:
  - drives `mem_read`=1 and `mem_addr`.
  - For a load: `load_data` ← extract(`mem_rdata`), then → FIN.
  - For a store: merge register ← `mem_rdata` with the target lane replaced by `req_wdata` low byte/half, then → WR.
- WR: `mem_write`=1, `mem_wdata` = latched word (word store) or merge register (sub-word store), then → FIN.
- FIN:
  - Pulses `done`=1, or `misaligned`=1 if the error flag is set; the two are never both 1.
  - Always → IDLE. A `req_valid` seen in FIN is ignored and is accepted in the following IDLE cycle.
- Lanes are little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; half h = bits [16h+15:16h], h = addr[1].
- Extraction: lane right-justified; upper bits are a copy of the lane MSB if `req_signed`, else 0.
- `stall` = (IDLE and `req_valid`) or RD or WR. `stall`=0 in FIN.
- Outside RD/WR: `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- `load_data` changes only at the end of a load's RD cycle. Stores and misaligned requests leave it unchanged.

## Timing
- Reset values: state IDLE; `stall`, `done`, `misaligned`, `mem_read`, `mem_write` = 0; `load_data`, `mem_addr`, `mem_wdata` = 0; merge register 0.
- `mem_read` and `mem_write` are gated by `!reset`. If reset is asserted in WR, no write occurs, the next state is IDLE, and no `done` is issued.
- Latency, counting the accept cycle as cycle 0:
  - load: `done` in cycle 2, `load_data` valid from cycle 2;
  - word store: write in cycle 1, `done` in cycle 2;
  - byte/half store: read in cycle 1, write in cycle 2, `done` in cycle 3;
  - misaligned: pulse in cycle 1, no memory access.
- Back-to-back: the next request is accepted no earlier than the cycle after FIN.
- Address wrap: bits above ADDR_BITS+1 are ignored; addresses alias modulo 2^(ADDR_BITS+2) bytes.

## Test plan
- Load word 0x8000_00F0 at addr 0x10, size 10 → `stall` high in cycles 0–1; `mem_addr`=4 in RD; `done` and `load_data`=0x8000_00F0 in cycle 2.
- Same word, byte load at addr 0x10, signed → `load_data`=0xFFFF_FFF0; unsigned → 0x0000_00F0. Half load at addr 0x12, signed → 0xFFFF_8000.
- Memory word 4 = 0x1122_3344; store byte 0xAB to addr 0x11 → RD then WR, `mem_wdata`=0x1122_AB44, `done` in cycle 3. Store half 0xBEEF to addr 0x12 → 0xBEEF_3344.
- Word load at addr 0x13; half store at 0x11; size 11 → `misaligned` pulse in cycle 1; `mem_read`=`mem_write`=0 throughout; `load_data` unchanged.
- Byte store with `reset` asserted in the WR cycle → no write (memory word keeps its old value), all outputs 0 next cycle, no `done`.
- Two consecutive word stores with `req_valid` held high → second accepted in the cycle after the first `done`; each write occurs exactly once.
